// File: rtl/pn_pkg.sv
// pn_pkg: shared types and helpers for the packet-buffer ring controller.
//   buf_state_t  : lifecycle state of one packet buffer
//   OWN_*        : 2-bit per-buffer owner codes driven on buf_sel
//   ptr_inc      : ring pointer increment modulo the buffer count
package pn_pkg;

    typedef enum logic [2:0] {
        FREE,
        SN,
        READY,
        CPU,
        ACC,
        REJ,
        FWD
    } buf_state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_SN   = 2'b01;
    localparam logic [1:0] OWN_CPU  = 2'b10;
    localparam logic [1:0] OWN_FWD  = 2'b11;

    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned num_bufs);
        return (ptr + 1 >= num_bufs) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/pn_agent_hs.sv
// pn_agent_hs: claim/busy/done-ack handshake tracker for one agent.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_avail       : the buffer at this agent's pointer is in the offerable state
//   i_claim_ack   : agent accepts the offered buffer
//   i_done        : agent finished with its buffer (level, held until ack)
//   o_rdy         : buffer offered (idle and available)
//   o_claim       : claim event this cycle
//   o_done_ev     : done event this cycle (buffer released at the coming edge)
//   o_busy        : agent currently owns a buffer
//   o_done_ack    : one-cycle acknowledge following a done event
module pn_agent_hs (
    input  logic clk,
    input  logic rst_n,
    input  logic i_avail,
    input  logic i_claim_ack,
    input  logic i_done,
    output logic o_rdy,
    output logic o_claim,
    output logic o_done_ev,
    output logic o_busy,
    output logic o_done_ack
);

    logic r_busy;
    logic r_done_ack;

    assign o_rdy      = !r_busy && i_avail;
    assign o_claim    = o_rdy && i_claim_ack;
    // The ack-pending term stops a still-held done level from firing twice.
    assign o_done_ev  = i_done && r_busy && !r_done_ack;
    assign o_busy     = r_busy;
    assign o_done_ack = r_done_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= 1'b0;
            r_done_ack <= 1'b0;
        end else begin
            if (o_claim) begin
                r_busy <= 1'b1;
            end else if (o_done_ev) begin
                r_busy <= 1'b0;
            end
            r_done_ack <= o_done_ev;
        end
    end

endmodule

// File: rtl/pn_ctrl.sv
// pn_ctrl: buffer-rotation controller for NUM_BUFS packet buffers kept as an ordered ring.
// Buffers move FREE -> SN -> READY -> CPU -> ACC/REJ -> FWD -> FREE; rejected buffers are
// drained back to FREE by the forwarder pointer without being offered.
//   clk, rst_n                        : clock, asynchronous active-low reset
//   A_done / A_done_ack               : snooper done level and its one-cycle ack
//   rdy_for_A / rdy_for_A_ack         : free buffer offer and snooper claim
//   sn_start                          : claim strobe for the snooper buffer length reset
//   B_acc, B_rej / B_done_ack         : CPU verdict levels and their one-cycle ack
//   rdy_for_B / rdy_for_B_ack         : filled buffer offer and CPU claim
//   C_done / C_done_ack               : forwarder done level and its one-cycle ack
//   rdy_for_C / rdy_for_C_ack         : accepted buffer offer and forwarder claim
//   sn_sel, cpu_sel, fwd_sel          : buffer index + 1 owned by each agent, 0 when none
//   buf_sel                           : 2-bit owner code per buffer
//   free_cnt                          : number of FREE buffers
module pn_ctrl
    import pn_pkg::*;
#(
    parameter int unsigned NUM_BUFS  = 4,
    parameter int unsigned SEL_WIDTH = $clog2(NUM_BUFS + 1),
    parameter int unsigned CNT_WIDTH = $clog2(NUM_BUFS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  A_done,
    output logic                  A_done_ack,
    output logic                  rdy_for_A,
    input  logic                  rdy_for_A_ack,
    output logic                  sn_start,
    input  logic                  B_acc,
    input  logic                  B_rej,
    output logic                  B_done_ack,
    output logic                  rdy_for_B,
    input  logic                  rdy_for_B_ack,
    input  logic                  C_done,
    output logic                  C_done_ack,
    output logic                  rdy_for_C,
    input  logic                  rdy_for_C_ack,
    output logic [SEL_WIDTH-1:0]  sn_sel,
    output logic [SEL_WIDTH-1:0]  cpu_sel,
    output logic [SEL_WIDTH-1:0]  fwd_sel,
    output logic [2*NUM_BUFS-1:0] buf_sel,
    output logic [CNT_WIDTH-1:0]  free_cnt
);

    localparam int unsigned PTR_W = $clog2(NUM_BUFS);

    buf_state_t r_state   [NUM_BUFS];
    buf_state_t w_state_d [NUM_BUFS];

    logic [PTR_W-1:0]     r_sn_ptr, r_cpu_ptr, r_fwd_ptr;
    logic [PTR_W-1:0]     w_sn_ptr_d, w_cpu_ptr_d, w_fwd_ptr_d;
    logic [CNT_WIDTH-1:0] r_free_cnt, w_free_cnt_d;

    logic w_sn_avail, w_sn_claim, w_sn_done, w_sn_busy;
    logic w_cpu_avail, w_cpu_claim, w_cpu_done, w_cpu_busy;
    logic w_fwd_avail, w_fwd_claim, w_fwd_done, w_fwd_busy;
    logic w_drain;
    logic w_free_inc;

    assign w_sn_avail  = (r_state[r_sn_ptr] == FREE);
    assign w_cpu_avail = (r_state[r_cpu_ptr] == READY);
    assign w_fwd_avail = (r_state[r_fwd_ptr] == ACC);

    pn_agent_hs u_sn_hs (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_avail     (w_sn_avail),
        .i_claim_ack (rdy_for_A_ack),
        .i_done      (A_done),
        .o_rdy       (rdy_for_A),
        .o_claim     (w_sn_claim),
        .o_done_ev   (w_sn_done),
        .o_busy      (w_sn_busy),
        .o_done_ack  (A_done_ack)
    );

    pn_agent_hs u_cpu_hs (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_avail     (w_cpu_avail),
        .i_claim_ack (rdy_for_B_ack),
        .i_done      (B_acc || B_rej),
        .o_rdy       (rdy_for_B),
        .o_claim     (w_cpu_claim),
        .o_done_ev   (w_cpu_done),
        .o_busy      (w_cpu_busy),
        .o_done_ack  (B_done_ack)
    );

    pn_agent_hs u_fwd_hs (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_avail     (w_fwd_avail),
        .i_claim_ack (rdy_for_C_ack),
        .i_done      (C_done),
        .o_rdy       (rdy_for_C),
        .o_claim     (w_fwd_claim),
        .o_done_ev   (w_fwd_done),
        .o_busy      (w_fwd_busy),
        .o_done_ack  (C_done_ack)
    );

    assign sn_start = w_sn_claim;

    // A rejected buffer at the forwarder pointer is recycled while the forwarder is idle.
    assign w_drain    = !w_fwd_busy && (r_state[r_fwd_ptr] == REJ);
    assign w_free_inc = w_fwd_done || w_drain;

    // Each event touches the buffer at its own pointer; ring ordering keeps those distinct
    // whenever events coincide, since each requires a different current state.
    always_comb begin
        w_state_d   = r_state;
        w_sn_ptr_d  = r_sn_ptr;
        w_cpu_ptr_d = r_cpu_ptr;
        w_fwd_ptr_d = r_fwd_ptr;

        if (w_sn_claim) begin
            w_state_d[r_sn_ptr] = SN;
        end
        if (w_sn_done) begin
            w_state_d[r_sn_ptr] = READY;
            w_sn_ptr_d          = PTR_W'(ptr_inc(32'(r_sn_ptr), NUM_BUFS));
        end

        if (w_cpu_claim) begin
            w_state_d[r_cpu_ptr] = CPU;
        end
        if (w_cpu_done) begin
            // Reject dominates when both verdicts are raised together.
            w_state_d[r_cpu_ptr] = B_rej ? REJ : ACC;
            w_cpu_ptr_d          = PTR_W'(ptr_inc(32'(r_cpu_ptr), NUM_BUFS));
        end

        if (w_fwd_claim) begin
            w_state_d[r_fwd_ptr] = FWD;
        end
        if (w_free_inc) begin
            w_state_d[r_fwd_ptr] = FREE;
            w_fwd_ptr_d          = PTR_W'(ptr_inc(32'(r_fwd_ptr), NUM_BUFS));
        end
    end

    always_comb begin
        w_free_cnt_d = r_free_cnt;
        case ({w_sn_claim, w_free_inc})
            2'b10:   w_free_cnt_d = r_free_cnt - CNT_WIDTH'(1);
            2'b01:   w_free_cnt_d = r_free_cnt + CNT_WIDTH'(1);
            default: w_free_cnt_d = r_free_cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_BUFS; k++) begin
                r_state[k] <= FREE;
            end
            r_sn_ptr   <= '0;
            r_cpu_ptr  <= '0;
            r_fwd_ptr  <= '0;
            r_free_cnt <= CNT_WIDTH'(NUM_BUFS);
        end else begin
            r_state    <= w_state_d;
            r_sn_ptr   <= w_sn_ptr_d;
            r_cpu_ptr  <= w_cpu_ptr_d;
            r_fwd_ptr  <= w_fwd_ptr_d;
            r_free_cnt <= w_free_cnt_d;
        end
    end

    assign free_cnt = r_free_cnt;

    // Pointers only advance on release, so while busy the pointer still names the owned buffer.
    assign sn_sel  = w_sn_busy  ? SEL_WIDTH'(r_sn_ptr)  + SEL_WIDTH'(1) : '0;
    assign cpu_sel = w_cpu_busy ? SEL_WIDTH'(r_cpu_ptr) + SEL_WIDTH'(1) : '0;
    assign fwd_sel = w_fwd_busy ? SEL_WIDTH'(r_fwd_ptr) + SEL_WIDTH'(1) : '0;

    always_comb begin
        buf_sel = '0;
        for (int k = 0; k < NUM_BUFS; k++) begin
            case (r_state[k])
                SN:      buf_sel[2*k +: 2] = OWN_SN;
                CPU:     buf_sel[2*k +: 2] = OWN_CPU;
                FWD:     buf_sel[2*k +: 2] = OWN_FWD;
                default: buf_sel[2*k +: 2] = OWN_NONE;
            endcase
        end
    end

endmodule

// File: tb/tb_pn_ctrl.sv
// tb_pn_ctrl: randomized bench for pn_ctrl (NUM_BUFS=4) against a packet-sequence model.
// The model counts packets through each lifecycle stage; packet s lives in buffer s mod N,
// and verdicts wait in a queue in arrival order.
module tb_pn_ctrl;

    localparam int N  = 4;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          A_done, A_done_ack, rdy_for_A, rdy_for_A_ack, sn_start;
    logic          B_acc, B_rej, B_done_ack, rdy_for_B, rdy_for_B_ack;
    logic          C_done, C_done_ack, rdy_for_C, rdy_for_C_ack;
    logic [SW-1:0] sn_sel, cpu_sel, fwd_sel;
    logic [2*N-1:0] buf_sel;
    logic [SW-1:0] free_cnt;

    always #5 clk = ~clk;

    pn_ctrl #(.NUM_BUFS(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .A_done        (A_done),
        .A_done_ack    (A_done_ack),
        .rdy_for_A     (rdy_for_A),
        .rdy_for_A_ack (rdy_for_A_ack),
        .sn_start      (sn_start),
        .B_acc         (B_acc),
        .B_rej         (B_rej),
        .B_done_ack    (B_done_ack),
        .rdy_for_B     (rdy_for_B),
        .rdy_for_B_ack (rdy_for_B_ack),
        .C_done        (C_done),
        .C_done_ack    (C_done_ack),
        .rdy_for_C     (rdy_for_C),
        .rdy_for_C_ack (rdy_for_C_ack),
        .sn_sel        (sn_sel),
        .cpu_sel       (cpu_sel),
        .fwd_sel       (fwd_sel),
        .buf_sel       (buf_sel),
        .free_cnt      (free_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Packet counters: started (snooper claims), written, cpu_cl (CPU claims), verdicted,
    // retired (forwarded or drained). Verdicts awaiting retirement: 1 = reject.
    int started, written, cpu_cl, verdicted, retired;
    bit fwd_busy, a_ack, b_ack, c_ack;
    bit vq[$];

    // Agent activity rates in percent, varied per phase.
    int p_ack_a, p_ack_b, p_ack_c, p_done, p_rej;

    task automatic model_reset();
        started = 0; written = 0; cpu_cl = 0; verdicted = 0; retired = 0;
        fwd_busy = 0; a_ack = 0; b_ack = 0; c_ack = 0;
        vq.delete();
    endtask

    task automatic check_all();
        bit sn_busy, cpu_busy, ea, eb, ec;
        logic [2*N-1:0] bs;
        sn_busy  = started > written;
        cpu_busy = cpu_cl > verdicted;
        ea = !sn_busy && (started - retired < N);
        eb = !cpu_busy && (cpu_cl < written);
        ec = !fwd_busy && (vq.size() > 0) && !vq[0];
        bs = '0;
        if (sn_busy)  bs[2*(written % N) +: 2] = 2'b01;
        if (cpu_busy) bs[2*(verdicted % N) +: 2] = 2'b10;
        if (fwd_busy) bs[2*(retired % N) +: 2] = 2'b11;
        check("rdy_for_A", 32'(rdy_for_A), 32'(ea));
        check("rdy_for_B", 32'(rdy_for_B), 32'(eb));
        check("rdy_for_C", 32'(rdy_for_C), 32'(ec));
        check("sn_start", 32'(sn_start), 32'(ea && rdy_for_A_ack));
        check("A_done_ack", 32'(A_done_ack), 32'(a_ack));
        check("B_done_ack", 32'(B_done_ack), 32'(b_ack));
        check("C_done_ack", 32'(C_done_ack), 32'(c_ack));
        check("sn_sel", 32'(sn_sel), sn_busy ? 32'(written % N + 1) : 32'd0);
        check("cpu_sel", 32'(cpu_sel), cpu_busy ? 32'(verdicted % N + 1) : 32'd0);
        check("fwd_sel", 32'(fwd_sel), fwd_busy ? 32'(retired % N + 1) : 32'd0);
        check("buf_sel", 32'(buf_sel), 32'(bs));
        check("free_cnt", 32'(free_cnt), 32'(N - (started - retired)));
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_step();
        bit sn_busy, cpu_busy, cl_a, dn_a, cl_b, dn_b, cl_c, dn_c, drain;
        sn_busy  = started > written;
        cpu_busy = cpu_cl > verdicted;
        cl_a  = !sn_busy && (started - retired < N) && rdy_for_A_ack;
        dn_a  = A_done && sn_busy && !a_ack;
        cl_b  = !cpu_busy && (cpu_cl < written) && rdy_for_B_ack;
        dn_b  = (B_acc || B_rej) && cpu_busy && !b_ack;
        cl_c  = !fwd_busy && (vq.size() > 0) && !vq[0] && rdy_for_C_ack;
        dn_c  = C_done && fwd_busy && !c_ack;
        drain = !fwd_busy && (vq.size() > 0) && vq[0];
        if (dn_c || drain) begin
            void'(vq.pop_front());
            retired++;
        end
        if (dn_b) begin
            vq.push_back(B_rej);
            verdicted++;
        end
        if (cl_a) started++;
        if (dn_a) written++;
        if (cl_b) cpu_cl++;
        if (cl_c) fwd_busy = 1;
        else if (dn_c) fwd_busy = 0;
        a_ack = dn_a;
        b_ack = dn_b;
        c_ack = dn_c;
    endtask

    function automatic bit roll(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    // Done levels are held until their ack is seen, then dropped; occasionally raised while idle.
    task automatic drive_random();
        rdy_for_A_ack = roll(p_ack_a);
        rdy_for_B_ack = roll(p_ack_b);
        rdy_for_C_ack = roll(p_ack_c);
        if (A_done) A_done = !a_ack;
        else        A_done = roll((started > written) ? p_done : 2);
        if (B_acc || B_rej) begin
            if (b_ack) begin
                B_acc = 0;
                B_rej = 0;
            end
        end else if (roll((cpu_cl > verdicted) ? p_done : 2)) begin
            if (roll(10)) begin
                B_acc = 1; B_rej = 1;
            end else if (roll(p_rej)) begin
                B_rej = 1;
            end else begin
                B_acc = 1;
            end
        end
        if (C_done) C_done = !c_ack;
        else        C_done = roll(fwd_busy ? p_done : 2);
    endtask

    task automatic drive_idle();
        A_done = 0; B_acc = 0; B_rej = 0; C_done = 0;
        rdy_for_A_ack = 0; rdy_for_B_ack = 0; rdy_for_C_ack = 0;
    endtask

    task automatic new_phase(input int kind);
        case (kind)
            0: begin p_ack_a = 80; p_ack_b = 60; p_ack_c = 60; p_done = 40; p_rej = 20; end
            1: begin p_ack_a = 90; p_ack_b = 0;  p_ack_c = 50; p_done = 50; p_rej = 20; end
            2: begin p_ack_a = 70; p_ack_b = 70; p_ack_c = 70; p_done = 50; p_rej = 70; end
            3: begin p_ack_a = 20; p_ack_b = 90; p_ack_c = 90; p_done = 60; p_rej = 30; end
            default: begin p_ack_a = 90; p_ack_b = 80; p_ack_c = 10; p_done = 30; p_rej = 10; end
        endcase
    endtask

    initial begin
        rst_n = 0;
        drive_idle();
        model_reset();
        new_phase(0);
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1;
        #1 check_all();

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc % 150 == 0) new_phase(int'($urandom_range(4)));
            if (cyc == 1700 || cyc == 3100) begin
                #2;
                rst_n = 0;
                drive_idle();
                model_reset();
                #1 check_all();
                @(negedge clk);
                #1 check_all();
                rst_n = 1;
            end
            drive_random();
            #1 check_all();
            model_step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pn_ctrl.md
Name: pn_ctrl

Overview:
- Next-generation buffer-rotation controller for the packet filter core. Generalises the fixed three-buffer ping/pang/pong controller to NUM_BUFS buffers arranged as an ordered ring.
- Tracks each buffer's lifecycle: snooper write, CPU filter, forwarder read. Packets leave in the same order they arrived.
- Drives the per-agent and per-buffer select buses consumed by the mux fabric.
- Adds two things the three-buffer controller lacks: automatic draining of rejected buffers, and a free-buffer count output.

Parameters:
- NUM_BUFS, 4, number of packet buffers (legal range 3..15).
- SEL_WIDTH, $clog2(NUM_BUFS+1), width of each agent select (0 = no buffer, k = buffer k-1).
- CNT_WIDTH, $clog2(NUM_BUFS+1), width of free_cnt.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- A_done  in  1  snooper finished writing current buffer (level, held until A_done_ack).
- A_done_ack  out  1  one-cycle acknowledge of A_done.
- rdy_for_A  out  1  a free buffer is available to the snooper.
- rdy_for_A_ack  in  1  snooper claims the offered buffer.
- sn_start  out  1  rdy_for_A && rdy_for_A_ack; drives length reset of the claimed buffer.
- B_acc, B_rej  in  1 each  CPU verdict (level, held until B_done_ack).
- B_done_ack  out  1  one-cycle acknowledge of the verdict.
- rdy_for_B  out  1  a filled buffer is available to the CPU.
- rdy_for_B_ack  in  1  CPU claims it.
- C_done  in  1  forwarder finished (level, held until C_done_ack).
- C_done_ack  out  1  one-cycle acknowledge.
- rdy_for_C  out  1  an accepted buffer is available to the forwarder.
- rdy_for_C_ack  in  1  forwarder claims it.
- sn_sel, cpu_sel, fwd_sel  out  SEL_WIDTH each  buffer owned by each agent (0 = none).
- buf_sel  out  2*NUM_BUFS  per-buffer owner, 2 bits per buffer: 00 none, 01 snooper, 10 CPU, 11 forwarder.
- free_cnt  out  CNT_WIDTH  number of buffers in FREE.

Behaviour:
- Per-buffer state register, one of: FREE, SN, READY, CPU, ACC, REJ, FWD.
- Three ring pointers: sn_ptr, cpu_ptr, fwd_ptr. Each increments mod NUM_BUFS, only on the events listed below.
- Reset (async, rst_n low):
  - all buffers FREE; all pointers 0.
  - all acks, rdy, sel and buf_sel outputs 0; free_cnt = NUM_BUFS.
  - Mid-operation reset abandons every buffer; no acks are issued.
- rdy outputs are combinational from registered state:
  - rdy_for_A = !sn_busy && state[sn_ptr]==FREE
  - rdy_for_B = !cpu_busy && state[cpu_ptr]==READY
  - rdy_for_C = !fwd_busy && state[fwd_ptr]==ACC
- Claim: at the edge where rdy && ack, the buffer moves SN/CPU/FWD and the agent becomes busy. The agent's sel = ptr+1 from the next cycle.
- Snooper done: when A_done && sn_busy && !A_done_ack:
  - next cycle A_done_ack=1 for exactly one cycle;
  - buffer SN->READY; sn_ptr++; sn_sel=0; busy clears.
  - A_done while idle is ignored.
- CPU verdict: same pattern as snooper done.
  - acc -> ACC; rej -> REJ.
  - acc and rej together: treated as reject.
  - cpu_ptr++ on either verdict.
- Forwarder done: buffer FWD->FREE; fwd_ptr++; one-cycle C_done_ack.
- Reject drain: when !fwd_busy && state[fwd_ptr]==REJ, in one cycle the buffer goes FREE and fwd_ptr++. This repeats one buffer per cycle; rdy_for_C stays low while draining.
- Simultaneous events on different agents are applied in the same cycle. Ring ordering guarantees each buffer has at most one owner.
- free_cnt is registered and updated in the same cycle as the state change:
  - decrements on snooper claim;
  - increments on forwarder done or reject drain;
  - net 0 when both happen in one cycle.
- Full ring: every buffer non-FREE means rdy_for_A stays low. Empty ring means rdy_for_B and rdy_for_C stay low.
- Ack held high by an agent with nothing offered has no effect.

Decomposition:
- Shared package pn_pkg:
  - buf_state_t enum (FREE..FWD);
  - owner encoding constants OWN_NONE/OWN_SN/OWN_CPU/OWN_FWD;
  - function ptr_inc (mod NUM_BUFS).
- One sub-module, pn_agent_hs: generic claim/busy/done-ack handshake tracker, instantiated three times.
- Ring state array and pointer logic stay in pn_ctrl.

Test Plan (NUM_BUFS=4):
- Reset release -> free_cnt=4, rdy_for_A=1, rdy_for_B=rdy_for_C=0, all sel=0. Assert rst_n mid-packet -> same values immediately (asynchronous).
- Single packet end to end, accepted:
  - A claim -> sn_sel=1, sn_start pulse.
  - A_done -> A_done_ack one cycle; rdy_for_B=1.
  - B claim, B_acc -> rdy_for_C=1.
  - C claim, C_done -> free_cnt=4; all pointers=1.
- Four packets written with no CPU activity -> free_cnt=0; rdy_for_A=0 on the fifth attempt; buf_sel=0 (all owners none, all buffers READY).
- Packets 0 and 1 rejected, packet 2 accepted -> fwd_ptr drains 0→1→2 in two cycles; rdy_for_C rises on the third cycle; fwd_sel=3 after claim.
- Same-cycle B_acc and B_rej -> buffer REJ, drained, never offered to the forwarder.
- Forwarder done and snooper claim in the same cycle -> free_cnt unchanged; ring wraps with sn_ptr 3→0 correctly.
